// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised RX line, oversampled start/data/parity/stop
// sampling driven by an external tick, with framing and parity error flags.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_sys_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clk_en,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err;

  logic mid_start, bit_end, last_bit;
  assign mid_start = (tick_cnt == TICK_W'(OVERSAMPLE/2 - 1));
  assign bit_end   = (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign last_bit  = (bit_cnt == BIT_W'(DATA_BITS - 1));
  assign o_busy    = (state != S_IDLE);

  // NOTE: synchroniser flops reset to 1 so an idle (high) line is not seen as a start bit.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: state and all registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (i_clk_en) begin
      unique case (state)
        S_IDLE:   if (!rx_s) state_nxt = S_START;
        S_START:  if (mid_start) state_nxt = rx_s ? S_IDLE : S_DATA;
        S_DATA:   if (bit_end && last_bit) state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        S_PARITY: if (bit_end) state_nxt = S_STOP;
        S_STOP:   if (bit_end) state_nxt = rx_s ? S_IDLE : S_BREAK;
        S_BREAK:  if (rx_s) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      par_err      <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_clk_en) begin
        unique case (state)
          S_START: begin
            if (mid_start) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              par_err  <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (bit_end) begin
              tick_cnt       <= '0;
              shift[bit_cnt] <= rx_s;
              bit_cnt        <= bit_cnt + 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_PARITY: begin
            if (bit_end) begin
              tick_cnt <= '0;
              par_err  <= ((^{shift, rx_s}) != (PARITY_ODD != 0));
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (bit_end) begin
              tick_cnt     <= '0;
              o_valid      <= 1'b1;
              o_data       <= shift;
              o_frame_err  <= ~rx_s;
              o_parity_err <= par_err;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: tick_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames on an 8N1 and an 8E1
// instance, scoreboard-checked outputs, plus glitch, break and reset sequences.
module tb_uart_rx;

  localparam int BIT_CYC = 160;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;
  logic line = 1'b1;
  logic sel = 1'b0;
  logic rx_a, rx_b;
  int   div_cnt = 0;

  logic [7:0] data_a, data_b;
  logic valid_a, fe_a, pe_a, busy_a;
  logic valid_b, fe_b, pe_b, busy_b;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct packed {
    logic       sel;
    logic [7:0] data;
    logic       use_par;
    logic       par_bit;
    logic       stop;
    logic       gap;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  assign rx_a = sel ? 1'b1 : line;
  assign rx_b = sel ? line : 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div_cnt <= (div_cnt == 9) ? 0 : div_cnt + 1;
    clk_en  <= (div_cnt == 9);
  end

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_rx(rx_a),
    .o_data(data_a), .o_valid(valid_a), .o_frame_err(fe_a),
    .o_parity_err(pe_a), .o_busy(busy_a)
  );

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_rx(rx_b),
    .o_data(data_b), .o_valid(valid_b), .o_frame_err(fe_b),
    .o_parity_err(pe_b), .o_busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_a) begin
      check("sb_a_expected", 32'(q_a.size() > 0), 32'd1);
      if (q_a.size() > 0) begin
        ea = q_a.pop_front();
        check("a_data", 32'(data_a), 32'(ea.data));
        check("a_frame_err", 32'(fe_a), 32'(ea.fe));
        check("a_parity_err", 32'(pe_a), 32'(ea.pe));
      end
    end
    if (rst_n && valid_b) begin
      check("sb_b_expected", 32'(q_b.size() > 0), 32'd1);
      if (q_b.size() > 0) begin
        eb = q_b.pop_front();
        check("b_data", 32'(data_b), 32'(eb.data));
        check("b_frame_err", 32'(fe_b), 32'(eb.fe));
        check("b_parity_err", 32'(pe_b), 32'(eb.pe));
      end
    end
  end

  task automatic drive_bit(input logic v);
    @(negedge clk);
    line = v;
    repeat (BIT_CYC - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    vec_t vecs[10];
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_errs", 32'({fe_a, pe_a}), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    idle(50);

    for (int i = 0; i < 10; i++) begin
      sel = vecs[i].sel;
      if (vecs[i].sel) q_b.push_back('{vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_pe});
      else             q_a.push_back('{vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_pe});
      send_frame(vecs[i].data, vecs[i].use_par, vecs[i].par_bit, vecs[i].stop);
      check($sformatf("drain_%0d", i), 32'(vecs[i].sel ? q_b.size() : q_a.size()), 32'd0);
      if (vecs[i].gap) begin
        line = 1'b1;
        idle(2 * BIT_CYC);
        check($sformatf("idle_busy_%0d", i), 32'(vecs[i].sel ? busy_b : busy_a), 32'd0);
        check($sformatf("hold_data_%0d", i), 32'(vecs[i].sel ? data_b : data_a),
              32'(vecs[i].exp_data));
        check($sformatf("hold_errs_%0d", i), 32'(vecs[i].sel ? {fe_b, pe_b} : {fe_a, pe_a}),
              32'({vecs[i].exp_fe, vecs[i].exp_pe}));
      end
    end

    // Short low pulse: start bit rejected at its midpoint.
    sel = 1'b0;
    line = 1'b0;
    idle(25);
    check("glitch_busy_high", 32'(busy_a), 32'd1);
    idle(5);
    line = 1'b1;
    idle(200);
    check("glitch_busy_low", 32'(busy_a), 32'd0);
    check("glitch_data_held", 32'(data_a), 32'hFF);

    // Break: stop bit low, line held low for five more bit times.
    q_a.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("break_drain", 32'(q_a.size()), 32'd0);
    idle(5 * BIT_CYC);
    check("break_busy", 32'(busy_a), 32'd1);
    check("break_fe_held", 32'(fe_a), 32'd1);
    line = 1'b1;
    idle(40);
    check("break_exit", 32'(busy_a), 32'd0);
    q_a.push_back('{8'h0F, 1'b0, 1'b0});
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    check("after_break_drain", 32'(q_a.size()), 32'd0);
    idle(BIT_CYC);

    // Reset in the middle of the data bits.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check("mid_frame_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_data", 32'(data_a), 32'd0);
    check("async_rst_valid", 32'(valid_a), 32'd0);
    check("async_rst_errs", 32'({fe_a, pe_a}), 32'd0);
    check("async_rst_busy", 32'(busy_a), 32'd0);
    line = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(50);
    q_a.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("post_rst_drain", 32'(q_a.size()), 32'd0);
    idle(BIT_CYC);
    check("post_rst_busy", 32'(busy_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
